// File: rtl/hif_fir_sequencer.sv
// Frame-based FIR MAC at the read end of the sample queue: one tap per clock, saturated 16-bit result.
// Latency N_TAPS+1 cycles from the first sequencing-high cycle to the filt_vld pulse.
// No backpressure: the queue streams freely, a premature sequencing drop aborts the frame with seq_err.
module hif_fir_sequencer #(
    parameter int N_TAPS = 1531
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] smpl_in,
    input  logic        sequencing,
    input  logic [15:0] coeff,
    output logic [10:0] coeff_addr,
    output logic [15:0] filt_out,
    output logic        filt_vld,
    output logic        seq_err
);

    localparam int          ACC_W = 32 + $clog2(N_TAPS);
    localparam int          SH_W  = ACC_W - 15;
    localparam logic [10:0] LAST  = 11'(N_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAC      = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [10:0]               addr_q, addr_d;
    logic                      all_iss_q, all_iss_d;
    logic                      mac_en_q, mac_en_d;
    logic                      mac_first_q, mac_first_d;
    logic                      mac_last_q, mac_last_d;
    logic                      seq_d1_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]               filt_q, filt_d;
    logic                      err_q, err_d;

    logic                      start;
    logic                      issue_mac;
    logic                      abort;
    logic                      finish;
    logic signed [31:0]        prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [SH_W-1:0]    res_hi;
    logic [15:0]               filt_sat;

    // A new frame may also begin in DONE when the queue dropped sequencing for exactly one cycle.
    assign start     = sequencing && ((state_q == IDLE) || ((state_q == DONE) && !seq_d1_q));
    assign issue_mac = sequencing && (state_q == MAC) && !all_iss_q;
    assign abort     = !sequencing && (state_q == MAC) && !all_iss_q;
    assign finish    = (state_q == MAC) && mac_en_q && mac_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = MAC;
            end
            MAC: begin
                if (abort)       state_d = IDLE;
                else if (finish) state_d = DONE;
            end
            DONE: begin
                if (start)           state_d = MAC;
                else if (sequencing) state_d = WAIT_LOW;
                else                 state_d = IDLE;
            end
            WAIT_LOW: begin
                if (!sequencing) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        filt_vld   = (state_q == DONE);
        coeff_addr = addr_q;
        filt_out   = filt_q;
        seq_err    = err_q;
    end

    always_comb begin
        addr_d      = addr_q;
        all_iss_d   = all_iss_q;
        mac_en_d    = start || issue_mac;
        mac_first_d = start;
        mac_last_d  = issue_mac && (addr_q == LAST);
        if (start) begin
            addr_d    = 11'd1;
            all_iss_d = 1'b0;
        end else if (issue_mac) begin
            if (addr_q == LAST) all_iss_d = 1'b1;
            else                addr_d    = addr_q + 11'd1;
        end else if (abort || finish) begin
            addr_d    = 11'd0;
            all_iss_d = 1'b0;
        end
    end

    // The ROM word and queue sample for a tap issued last cycle arrive together now.
    always_comb begin
        prod     = $signed(smpl_in) * $signed(coeff);
        acc_sum  = {{(ACC_W-32){prod[31]}}, prod};
        if (!mac_first_q) acc_sum = acc_q + acc_sum;

        acc_d = acc_q;
        if (abort)         acc_d = '0;
        else if (mac_en_q) acc_d = acc_sum;

        res_hi = acc_sum[ACC_W-1:15];
        if (res_hi[SH_W-1:15] == {(SH_W-15){res_hi[15]}}) filt_sat = res_hi[15:0];
        else if (res_hi[SH_W-1])                            filt_sat = 16'h8000;
        else                                                filt_sat = 16'h7FFF;

        filt_d = finish ? filt_sat : filt_q;
        err_d  = abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            all_iss_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            seq_d1_q    <= 1'b0;
            acc_q       <= '0;
            filt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            all_iss_q   <= all_iss_d;
            mac_en_q    <= mac_en_d;
            mac_first_q <= mac_first_d;
            mac_last_q  <= mac_last_d;
            seq_d1_q    <= sequencing;
            acc_q       <= acc_d;
            filt_q      <= filt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_hif_fir_sequencer.sv
// Bench for hif_fir_sequencer: an 8-tap and a default-size instance fed from queue/ROM models,
// checked frame by frame against a plain-arithmetic dot-product model.
module tb_hif_fir_sequencer;

    localparam int N_SMALL = 8;
    localparam int N_BIG   = 1531;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        seq0, seq1;
    logic [15:0] nxt0, nxt1;
    logic [15:0] smpl0, smpl1;
    logic [15:0] coeff0, coeff1;
    logic [10:0] addr0, addr1;
    logic [15:0] out0, out1;
    logic        vld0, vld1;
    logic        err0, err1;

    logic [15:0] smp_mem [2][2048];
    logic [15:0] cof_mem [2][2048];
    logic [15:0] hold [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hif_fir_sequencer #(.N_TAPS(N_SMALL)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .smpl_in(smpl0), .sequencing(seq0), .coeff(coeff0),
        .coeff_addr(addr0), .filt_out(out0), .filt_vld(vld0), .seq_err(err0)
    );

    hif_fir_sequencer u_dut_big (
        .clk(clk), .rst_n(rst_n), .smpl_in(smpl1), .sequencing(seq1), .coeff(coeff1),
        .coeff_addr(addr1), .filt_out(out1), .filt_vld(vld1), .seq_err(err1)
    );

    // Synchronous coefficient ROMs and one-cycle queue read ports.
    always @(posedge clk) begin
        coeff0 <= cof_mem[0][addr0];
        coeff1 <= cof_mem[1][addr1];
        smpl0  <= nxt0;
        smpl1  <= nxt1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ntap(input int d);
        return (d == 0) ? N_SMALL : N_BIG;
    endfunction

    function automatic logic [15:0] sat_ref(input longint s);
        longint q;
        q = s >>> 15;
        if (q > 32767)  return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        return q[15:0];
    endfunction

    function automatic logic [15:0] expect_frame(input int d);
        longint s = 0;
        for (int i = 0; i < ntap(d); i++)
            s += longint'($signed(smp_mem[d][i])) * longint'($signed(cof_mem[d][i]));
        return sat_ref(s);
    endfunction

    task automatic drive(input int d, input logic s, input logic [15:0] v);
        if (d == 0) begin seq0 = s; nxt0 = v; end
        else        begin seq1 = s; nxt1 = v; end
    endtask

    task automatic observe(input int d, output logic [10:0] a, output logic [15:0] o,
                           output logic v, output logic e);
        if (d == 0) begin a = addr0; o = out0; v = vld0; e = err0; end
        else        begin a = addr1; o = out1; v = vld1; e = err1; end
    endtask

    // sequencing high for len cycles then low for gap cycles; expectations follow the frame rules.
    task automatic run_frame(input int d, input int len, input int gap, input string name);
        int          n = ntap(d);
        logic        full = (len >= n);
        logic [15:0] exp_new = expect_frame(d);
        int          t = (len + gap > n + 2) ? len + gap : n + 2;
        logic [10:0] a;
        logic [15:0] o;
        logic        v, e;
        for (int c = 0; c < t; c++) begin
            @(posedge clk); #1;
            drive(d, c < len, (c < n) ? smp_mem[d][c] : 16'($urandom));
            @(negedge clk);
            observe(d, a, o, v, e);
            if (c < len && c < n) check($sformatf("%s addr c%0d", name, c), 32'(a), 32'(c));
            check($sformatf("%s vld c%0d", name, c), 32'(v), 32'(full && c == n + 1));
            check($sformatf("%s err c%0d", name, c), 32'(e), 32'(!full && c == len + 1));
            if (full && c == n + 1)
                check($sformatf("%s result", name), 32'(o), 32'(exp_new));
            else if (!(full && c > n + 1))
                check($sformatf("%s hold c%0d", name, c), 32'(o), 32'(hold[d]));
        end
        if (full) hold[d] = exp_new;
        observe(d, a, o, v, e);
        check($sformatf("%s end out", name), 32'(o), 32'(hold[d]));
        check($sformatf("%s end addr", name), 32'(a), 32'd0);
    endtask

    task automatic randomize_mem(input int d);
        for (int i = 0; i < ntap(d); i++) begin
            smp_mem[d][i] = 16'($urandom);
            cof_mem[d][i] = 16'($urandom);
        end
    endtask

    initial begin
        logic [10:0] a;
        logic [15:0] o;
        logic        v, e;

        rst_n = 1'b0;
        drive(0, 1'b0, 16'd0);
        drive(1, 1'b0, 16'd0);
        hold[0] = 16'd0;
        hold[1] = 16'd0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2048; i++) begin
                smp_mem[d][i] = 16'd0;
                cof_mem[d][i] = 16'd0;
            end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            observe(d, a, o, v, e);
            check($sformatf("reset addr d%0d", d), 32'(a), 32'd0);
            check($sformatf("reset out d%0d", d),  32'(o), 32'd0);
            check($sformatf("reset vld d%0d", d),  32'(v), 32'd0);
            check($sformatf("reset err d%0d", d),  32'(e), 32'd0);
        end
        rst_n = 1'b1;

        randomize_mem(0);
        for (int i = 0; i < N_SMALL; i++) smp_mem[0][i] = 16'd0;
        smp_mem[0][0] = 16'h7FFF;
        cof_mem[0][0] = 16'h4000;
        run_frame(0, N_SMALL, 2, "impulse");
        check("impulse value", 32'(out0), 32'h3FFF);

        for (int i = 0; i < N_BIG; i++) begin
            smp_mem[1][i] = 16'h7FFF;
            cof_mem[1][i] = 16'h7FFF;
        end
        run_frame(1, N_BIG, 2, "sat_pos");
        check("sat_pos value", 32'(out1), 32'h7FFF);
        for (int i = 0; i < N_BIG; i++) cof_mem[1][i] = 16'h8000;
        run_frame(1, N_BIG, 2, "sat_neg");
        check("sat_neg value", 32'(out1), 32'h8000);

        for (int i = 0; i < N_SMALL; i++) begin
            smp_mem[0][i] = (i % 2 == 0) ? 16'd1000 : 16'hFC18;
            cof_mem[0][i] = 16'h7FFF;
        end
        run_frame(0, N_SMALL, 3, "mixed");
        check("mixed value", 32'(out0), 32'h0000);

        for (int k = 0; k < 6; k++) begin
            randomize_mem(0);
            run_frame(0, N_SMALL, 2 + int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
        end

        randomize_mem(0);
        run_frame(0, 4, 2, "abort");
        run_frame(0, N_SMALL, 2, "post_abort");

        for (int k = 0; k < 8; k++) begin
            randomize_mem(0);
            run_frame(0, int'($urandom_range(1, 12)), int'($urandom_range(1, 3)),
                      $sformatf("mix%0d", k));
        end

        randomize_mem(0);
        run_frame(0, 12, 1, "overlong");
        randomize_mem(0);
        run_frame(0, N_SMALL, 2, "after_gap1");

        randomize_mem(0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, smp_mem[0][c]);
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst addr", 32'(addr0), 32'd0);
        check("midrst out",  32'(out0),  32'd0);
        check("midrst vld",  32'(vld0),  32'd0);
        check("midrst err",  32'(err0),  32'd0);
        check("midrst big out", 32'(out1), 32'd0);
        hold[0] = 16'd0;
        hold[1] = 16'd0;
        drive(0, 1'b0, 16'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midrst quiet vld c%0d", c), 32'(vld0), 32'd0);
            check($sformatf("midrst quiet err c%0d", c), 32'(err0), 32'd0);
        end
        rst_n = 1'b1;
        randomize_mem(0);
        run_frame(0, N_SMALL, 2, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
